// File: rtl/neuron_stream_mac.sv
// neuron_stream_mac: streamed dot product of pixel/weight beats plus bias, saturated to 8.18.
// Define NEURON_RELU_EN to clamp negative results to zero.
module neuron_stream_mac #(
    parameter int NUM_INPUTS   = 784,
    parameter int NUM_LANES    = 16,
    parameter int PIXEL_WIDTH  = 10,
    parameter int WEIGHT_WIDTH = 19,
    parameter int OUTPUT_WIDTH = 26,
    parameter int ACC_WIDTH    = 42
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic signed [OUTPUT_WIDTH-1:0]       BIAS,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_LANES*PIXEL_WIDTH-1:0]     IN_PIXELS,
    input  logic [NUM_LANES*WEIGHT_WIDTH-1:0]    IN_WEIGHTS,
    output logic signed [OUTPUT_WIDTH-1:0]       OUT,
    output logic                                 done,
    input  logic                                 out_ready,
    output logic                                 sat,
    output logic                                 busy
);
    localparam int BEATS   = (NUM_INPUTS + NUM_LANES - 1) / NUM_LANES;
    localparam int CW      = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PW      = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
    localparam int MIN_ACC = PW + $clog2(NUM_INPUTS);
    localparam logic signed [ACC_WIDTH:0] MAXS = {{(ACC_WIDTH+2-OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINS = ~MAXS;
    localparam logic [OUTPUT_WIDTH-1:0] MAXO = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_WIDTH-1:0] MINO = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

    generate
        if (ACC_WIDTH < MIN_ACC) begin : g_acc_chk
            $error("neuron_stream_mac: ACC_WIDTH too small for NUM_INPUTS products");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic signed [ACC_WIDTH-1:0] acc, beat_sum;
    logic signed [OUTPUT_WIDTH-1:0] bias_q;
    logic signed [ACC_WIDTH:0] s;
    logic signed [PW-1:0] prod;
    logic [OUTPUT_WIDTH-1:0] res;
    logic start_ok, beat_ok, last, hi, lo, res_sat;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (beat_ok && last) state_nxt = FINISH;
            FINISH:  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == ACCUM;
        done     = state == DONE;
        busy     = state != IDLE;
    end

    assign start_ok = start && (state == IDLE || (state == DONE && out_ready));
    assign beat_ok  = in_valid && state == ACCUM;
    assign last     = cnt == CW'(BEATS - 1);

    // Lanes past NUM_INPUTS only exist on the tail beat and are dropped.
    always_comb begin
        beat_sum = '0;
        prod = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            prod = $signed({1'b0, IN_PIXELS[k*PIXEL_WIDTH +: PIXEL_WIDTH]}) * $signed(IN_WEIGHTS[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            if (int'(cnt) * NUM_LANES + k < NUM_INPUTS)
                beat_sum = beat_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        end
    end

    always_comb begin
        s  = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-OUTPUT_WIDTH){bias_q[OUTPUT_WIDTH-1]}}, bias_q};
        hi = s > MAXS;
        lo = s < MINS;
`ifdef NEURON_RELU_EN
        res     = hi ? MAXO : s[ACC_WIDTH] ? '0 : s[OUTPUT_WIDTH-1:0];
        res_sat = hi;
`else
        res     = hi ? MAXO : lo ? MINO : s[OUTPUT_WIDTH-1:0];
        res_sat = hi || lo;
`endif
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            OUT    <= '0;
            sat    <= 1'b0;
        end else begin
            if (start_ok) begin
                acc    <= '0;
                cnt    <= '0;
                bias_q <= BIAS;
            end else if (beat_ok) begin
                acc <= acc + beat_sum;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (state == FINISH) begin
                OUT <= res;
                sat <= res_sat;
            end
        end
endmodule

// File: tb/tb_neuron_stream_mac.sv
// tb_neuron_stream_mac: directed runs on a 5-input, 2-lane neuron checked against an arithmetic model.
module tb_neuron_stream_mac;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [25:0] BIAS = '0;
    logic [19:0] IN_PIXELS = '0;
    logic [37:0] IN_WEIGHTS = '0;
    logic [25:0] OUT;
    logic in_ready, done, sat, busy;
    logic [9:0]  pix [5];
    logic [18:0] wt [5];
    logic [25:0] exp_out = '0;
    logic exp_sat = 0;
    int checks = 0, errors = 0;

    neuron_stream_mac #(.NUM_INPUTS(5), .NUM_LANES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .BIAS(BIAS), .in_valid(in_valid), .in_ready(in_ready),
        .IN_PIXELS(IN_PIXELS), .IN_WEIGHTS(IN_WEIGHTS), .OUT(OUT), .done(done), .out_ready(out_ready),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Dot product from first principles: unsigned pixel times signed 1.18 weight, plus 8.18 bias.
    task automatic model(input logic [25:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < 5; i++) acc += longint'(pix[i]) * longint'($signed(wt[i]));
        exp_sat = 0;
        if (acc > 33554431) begin acc = 33554431; exp_sat = 1; end
`ifdef NEURON_RELU_EN
        if (acc < 0) acc = 0;
`else
        if (acc < -33554432) begin acc = -33554432; exp_sat = 1; end
`endif
        exp_out = acc[25:0];
    endtask

    always @(negedge clk) if (done) begin
        chk("out_vs_model", {6'd0, OUT}, {6'd0, exp_out});
        chk("sat_vs_model", {31'd0, sat}, {31'd0, exp_sat});
    end

    task automatic set_all(input logic [9:0] p, input logic [18:0] w);
        for (int i = 0; i < 5; i++) begin pix[i] = p; wt[i] = w; end
    endtask

    task automatic launch(input logic [25:0] b, input bit chain);
        BIAS = b; start = 1; out_ready = chain;
        @(posedge clk); #1;
        start = 0; out_ready = 0;
        model(b);
        chk("accum_entry", {30'd0, in_ready, busy}, 32'd3);
    endtask

    task automatic send_beat(input int b);
        int n = 0;
        for (int k = 0; k < 2; k++) begin
            int idx = b * 2 + k;
            IN_PIXELS[k*10 +: 10]  = idx < 5 ? pix[idx] : 10'd1023;
            IN_WEIGHTS[k*19 +: 19] = idx < 5 ? wt[idx] : 19'h7FFFF;
        end
        in_valid = 1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("beat_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic feed(input int gap, input bit poke);
        for (int b = 0; b < 3; b++) begin
            send_beat(b);
            if (b < 2) for (int g = 0; g < gap; g++) begin
                if (poke && b == 0 && g == 0) begin BIAS = 26'h1234567; start = 1; end
                @(posedge clk); #1;
                start = 0;
                chk("stall_in_ready", {31'd0, in_ready}, 1);
            end
        end
        chk("finish_no_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        chk("done_latency", {31'd0, done}, 1);
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("done_held", {31'd0, done}, 1);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("idle_after_accept", {30'd0, done, busy}, 0);
    endtask

    task automatic t1_data;
        for (int i = 0; i < 5; i++) begin pix[i] = 10'(i + 1); wt[i] = 19'h3FFFF; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        set_all(0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, in_ready, busy, done, sat, 2'b00}, 0);
        chk("reset_out", {6'd0, OUT}, 0);
        rst = 0;
        // +1.0 is not representable in 1.18, so 0x3FFFF stands in for it: 15*(2^18-1) + 2^18.
        t1_data();
        launch(26'h0040000, 0);
        feed(0, 0);
        chk("t1_out", {6'd0, OUT}, 32'h003FFFF1);
        chk("t1_sat", {31'd0, sat}, 0);
        drain(0);
        launch(26'h0040000, 0);
        feed(3, 1);
        chk("t2_out", {6'd0, OUT}, 32'h003FFFF1);
        drain(5);
        chk("t2_hold_after", {6'd0, OUT}, 32'h003FFFF1);
        set_all(10'd1023, 19'h3FFFF);
        launch(26'h0, 0);
        feed(0, 0);
        chk("t3_pos_out", {6'd0, OUT}, 32'h01FFFFFF);
        chk("t3_pos_sat", {31'd0, sat}, 1);
        drain(1);
        set_all(10'd1023, 19'h40000);
        launch(26'h0, 0);
        feed(1, 0);
`ifdef NEURON_RELU_EN
        chk("t3_neg_out", {6'd0, OUT}, 0);
        chk("t3_neg_sat", {31'd0, sat}, 0);
`else
        chk("t3_neg_out", {6'd0, OUT}, 32'h02000000);
        chk("t3_neg_sat", {31'd0, sat}, 1);
`endif
        drain(0);
        set_all(10'd1, 19'h7C000);
        launch(26'h0, 0);
        feed(0, 0);
`ifdef NEURON_RELU_EN
        chk("t4_out", {6'd0, OUT}, 0);
`else
        chk("t4_out", {6'd0, OUT}, 32'h03FEC000);
`endif
        chk("t4_sat", {31'd0, sat}, 0);
        drain(0);
        t1_data();
        launch(26'h0040000, 0);
        feed(0, 0);
        set_all(10'd3, 19'h08000);
        launch(26'h0080000, 1);
        feed(0, 0);
        chk("t5_chain_out", {6'd0, OUT}, 32'h000F8000);
        drain(0);
        t1_data();
        launch(26'h0040000, 0);
        send_beat(0);
        send_beat(1);
        #2 rst = 1;
        #1;
        chk("t6_async_ctrl", {29'd0, in_ready, busy, done}, 0);
        chk("t6_async_out", {6'd0, OUT}, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6_no_done", {30'd0, done, busy}, 0);
        end
        launch(26'h0040000, 0);
        feed(0, 0);
        chk("t6_rerun_out", {6'd0, OUT}, 32'h003FFFF1);
        drain(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
